// File: rtl/gb_ucode_pkg.sv
// Shared definitions for the micro-sequencer: control-word field positions, widths,
// sequencer state encoding and the interrupt-entry subop index.
package gb_ucode_pkg;

  localparam int UPC_W    = 7;
  localparam int CTRL_W   = 60;

  localparam int END_BIT  = 59;
  localparam int MEM_BIT  = 58;
  localparam int HALT_BIT = 57;

  localparam logic [UPC_W-1:0] INT_UPC = 7'd64;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_CB_FETCH,
    ST_HALT,
    ST_INT
  } state_t;

  // A memory subop holds the sequencer until the bus completes.
  function automatic logic is_stall(input logic [CTRL_W-1:0] word, input logic ready);
    return word[MEM_BIT] & ~ready;
  endfunction

endpackage

// File: rtl/microcode_seq.sv
// Micro-sequencer: opcode fetch, dispatch and subop stepping with memory stalls, HALT and
// interrupt entry. The 0xCB prefix path is compiled in only when GB_CB_PREFIX_EN is defined.
module microcode_seq
  import gb_ucode_pkg::*;
`ifdef GB_CB_PREFIX_EN
#(
  parameter logic [UPC_W-1:0] CB_BASE = 7'd0
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic [7:0]        mem_data,
  output logic              fetch_rd,
  output logic              pc_inc,
  output logic [7:0]        opcode,
  input  logic [UPC_W-1:0]  dispatch_upc,
  output logic [UPC_W-1:0]  upc,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  input  logic              irq_pending,
  input  logic              ime,
  output logic              irq_ack,
  output logic              halted
);

`ifdef GB_CB_PREFIX_EN
  localparam logic [7:0] CB_PREFIX = 8'hCB;
  logic r_cb;
`endif

  state_t           r_state;
  logic [7:0]       r_opcode;
  logic [UPC_W-1:0] r_upc;
  logic             r_pc_inc;
  logic             r_irq_ack;
  logic             w_stall;
  logic             w_end;

  assign w_stall = is_stall(ctrl_in, mem_ready);
  assign w_end   = ctrl_in[END_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_opcode  <= 8'h00;
      r_upc     <= '0;
      r_pc_inc  <= 1'b0;
      r_irq_ack <= 1'b0;
`ifdef GB_CB_PREFIX_EN
      r_cb      <= 1'b0;
`endif
    end else begin
      r_pc_inc  <= 1'b0;
      r_irq_ack <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_opcode <= mem_data;
            r_pc_inc <= 1'b1;
            r_state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
`ifdef GB_CB_PREFIX_EN
          // Second decode after a prefix: the latched byte indexes the CB half of the table.
          if (r_cb) begin
            r_cb    <= 1'b0;
            r_upc   <= dispatch_upc + CB_BASE;
            r_state <= ST_EXEC;
          end else if (r_opcode == CB_PREFIX) begin
            r_state <= ST_CB_FETCH;
          end else begin
            r_upc   <= dispatch_upc;
            r_state <= ST_EXEC;
          end
`else
          r_upc   <= dispatch_upc;
          r_state <= ST_EXEC;
`endif
        end
`ifdef GB_CB_PREFIX_EN
        ST_CB_FETCH: begin
          if (mem_ready) begin
            r_opcode <= mem_data;
            r_pc_inc <= 1'b1;
            r_cb     <= 1'b1;
            r_state  <= ST_DECODE;
          end
        end
`endif
        ST_EXEC: begin
          // Interrupts are only considered at an instruction boundary, and HALT takes priority.
          if (!w_stall) begin
            if (!w_end) begin
              r_upc <= r_upc + 1'b1;
            end else if (ctrl_in[HALT_BIT]) begin
              r_state <= ST_HALT;
            end else if (irq_pending && ime) begin
              r_irq_ack <= 1'b1;
              r_state   <= ST_INT;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_INT: begin
          r_upc   <= INT_UPC;
          r_state <= ST_EXEC;
        end
        ST_HALT: begin
          if (irq_pending) begin
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

`ifdef GB_CB_PREFIX_EN
  assign fetch_rd   = ~rst & ((r_state == ST_FETCH) | (r_state == ST_CB_FETCH));
`else
  assign fetch_rd   = ~rst & (r_state == ST_FETCH);
`endif
  assign ctrl_valid = (r_state == ST_EXEC);
  assign ctrl_out   = ctrl_valid ? ctrl_in : '0;
  assign halted     = (r_state == ST_HALT);
  assign pc_inc     = r_pc_inc;
  assign irq_ack    = r_irq_ack;
  assign opcode     = r_opcode;
  assign upc        = r_upc;

endmodule

// File: tb/tb_microcode_seq.sv
// Bench for microcode_seq: directed vector table, hand-built IRQ/HALT/reset sequences and a
// randomized run against an instruction-level model of the subop walk.
module tb_microcode_seq;
  import gb_ucode_pkg::*;

  logic              clk;
  logic              rst;
  logic              mem_ready;
  logic [7:0]        mem_data;
  logic              fetch_rd;
  logic              pc_inc;
  logic [7:0]        opcode;
  logic [UPC_W-1:0]  dispatch_upc;
  logic [UPC_W-1:0]  upc;
  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_out;
  logic              ctrl_valid;
  logic              irq_pending;
  logic              ime;
  logic              irq_ack;
  logic              halted;

  logic [UPC_W-1:0]  disp_rom [256];
  logic [CTRL_W-1:0] ctrl_rom [128];

  assign dispatch_upc = disp_rom[opcode];
  assign ctrl_in      = ctrl_rom[upc];

`ifdef GB_CB_PREFIX_EN
  microcode_seq #(.CB_BASE(7'd32)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_data(mem_data), .fetch_rd(fetch_rd),
    .pc_inc(pc_inc), .opcode(opcode), .dispatch_upc(dispatch_upc), .upc(upc),
    .ctrl_in(ctrl_in), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid),
    .irq_pending(irq_pending), .ime(ime), .irq_ack(irq_ack), .halted(halted));
`else
  microcode_seq dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_data(mem_data), .fetch_rd(fetch_rd),
    .pc_inc(pc_inc), .opcode(opcode), .dispatch_upc(dispatch_upc), .upc(upc),
    .ctrl_in(ctrl_in), .ctrl_out(ctrl_out), .ctrl_valid(ctrl_valid),
    .irq_pending(irq_pending), .ime(ime), .irq_ack(irq_ack), .halted(halted));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       op;
    logic [UPC_W-1:0] disp;
    int               nwords;
    int               mem_sub;
    int               waitc;
    int               exp_cycles;
    logic [UPC_W-1:0] exp_last;
  } vec_t;

  int n_chk;
  int n_fail;
  logic [UPC_W-1:0] exp_q [$];

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 30 && !fetch_rd; i++) cyc();
    chk("wait_fetch", 64'(fetch_rd), 64'd1);
  endtask

  // Present one opcode byte on the bus; returns at the DECODE-cycle sample point.
  task automatic issue(input logic [7:0] op);
    wait_fetch();
    mem_data  = op;
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
  endtask

  function automatic logic [CTRL_W-1:0] payload();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {3'b000, r[56:0]};
  endfunction

  task automatic load_vec(input vec_t v);
    logic [UPC_W-1:0]  idx;
    logic [CTRL_W-1:0] w;
    disp_rom[v.op] = v.disp;
    idx = v.disp;
    for (int k = 0; k < v.nwords; k++) begin
      w = payload();
      w[END_BIT] = (k == v.nwords - 1);
      w[MEM_BIT] = (k == v.mem_sub);
      ctrl_rom[idx] = w;
      idx = idx + 7'd1;
    end
  endtask

  // Model: an accepted opcode emits subops from its dispatch address up to the END word.
  task automatic push_walk(input logic [UPC_W-1:0] d);
    logic [UPC_W-1:0] idx;
    idx = d;
    for (int k = 0; k < 128; k++) begin
      exp_q.push_back(idx);
      if (ctrl_rom[idx][END_BIT]) break;
      idx = idx + 7'd1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    vec_t v;
    int lat, cnt, pcs, waited, acks, hcnt, exp_pc;
    logic done, prev_stall;
    logic [UPC_W-1:0] first, last, prev_upc, stall_idx, e;
    logic [CTRL_W-1:0] w;
    logic [7:0] b;

    n_chk = 0;
    n_fail = 0;
    vt[0] = '{8'h00, 7'd5,   1, -1, 0, 1, 7'd5};
    vt[1] = '{8'h3E, 7'd10,  3,  1, 3, 6, 7'd12};
    vt[2] = '{8'h77, 7'd126, 3, -1, 0, 3, 7'd0};
`ifdef GB_CB_PREFIX_EN
    vt[3] = '{8'hCA, 7'd20,  2,  1, 2, 4, 7'd21};
`else
    vt[3] = '{8'hCB, 7'd20,  2,  1, 2, 4, 7'd21};
`endif
    vt[4] = '{8'hFF, 7'd40,  1,  0, 0, 1, 7'd40};
    vt[5] = '{8'h42, 7'd90,  4,  0, 1, 5, 7'd93};

    for (int i = 0; i < 256; i++) disp_rom[i] = '0;
    for (int i = 0; i < 128; i++) ctrl_rom[i] = '0;
    rst = 1'b1; mem_ready = 1'b0; mem_data = 8'h00; irq_pending = 1'b0; ime = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_fetch_rd",   64'(fetch_rd),   64'd0);
    chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_ctrl_out",   64'(ctrl_out),   64'd0);
    chk("rst_pc_inc",     64'(pc_inc),     64'd0);
    chk("rst_irq_ack",    64'(irq_ack),    64'd0);
    chk("rst_halted",     64'(halted),     64'd0);
    chk("rst_upc",        64'(upc),        64'd0);
    chk("rst_opcode",     64'(opcode),     64'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_fetch_rd", 64'(fetch_rd), 64'd1);

    // Vector table: single instructions with optional memory wait states
    for (int r = 0; r < 6; r++) begin
      v = vt[r];
      load_vec(v);
      wait_fetch();
      mem_data = v.op;
      mem_ready = 1'b1;
      lat = -1; cnt = 0; pcs = 0; waited = 0; done = 1'b0; prev_stall = 1'b0;
      first = '0; last = '0; prev_upc = '0;
      stall_idx = v.disp + 7'(v.mem_sub);
      for (int t = 1; t <= 40 && !done; t++) begin
        cyc();
        mem_ready = 1'b1;
        if (pc_inc) pcs++;
        if (ctrl_valid) begin
          if (lat < 0) begin
            lat = t;
            first = upc;
          end
          if (prev_stall) chk("vec_stall_hold", 64'(upc), 64'(prev_upc));
          cnt++;
          last = upc;
          chk("vec_ctrl_word", 64'(ctrl_out), 64'(ctrl_rom[upc]));
          prev_stall = 1'b0;
          if (v.mem_sub >= 0 && upc == stall_idx && waited < v.waitc) begin
            mem_ready = 1'b0;
            waited++;
            prev_stall = 1'b1;
          end
          prev_upc = upc;
        end else if (lat >= 0) begin
          done = 1'b1;
          mem_ready = 1'b0;
          chk("vec_next_fetch", 64'(fetch_rd), 64'd1);
        end
      end
      mem_ready = 1'b0;
      chk("vec_done",       64'(done),  64'd1);
      chk("vec_latency",    64'(lat),   64'd2);
      chk("vec_ctrl_count", 64'(cnt),   64'(v.exp_cycles));
      chk("vec_first_upc",  64'(first), 64'(v.disp));
      chk("vec_last_upc",   64'(last),  64'(v.exp_last));
      chk("vec_pc_inc",     64'(pcs),   64'd1);
    end

    // Interrupt taken only at END, then entry sequence at INT_UPC
    disp_rom[8'h10] = 7'd50;
    w = payload(); ctrl_rom[50] = w;
    w = payload(); w[END_BIT] = 1'b1; ctrl_rom[51] = w;
    w = payload(); ctrl_rom[64] = w;
    w = payload(); w[END_BIT] = 1'b1; ctrl_rom[65] = w;
    issue(8'h10);
    irq_pending = 1'b1; ime = 1'b1;
    cyc(); chk("irq_w0_upc", 64'(upc), 64'd50);
    cyc(); chk("irq_no_split", 64'(upc), 64'd51);
    chk("irq_no_early_ack", 64'(irq_ack), 64'd0);
    cyc(); chk("irq_ack_pulse", 64'(irq_ack), 64'd1);
    chk("irq_int_novalid", 64'(ctrl_valid), 64'd0);
    cyc(); chk("irq_entry_upc", 64'(upc), 64'(INT_UPC));
    chk("irq_entry_valid", 64'(ctrl_valid), 64'd1);
    chk("irq_ack_single", 64'(irq_ack), 64'd0);
    ime = 1'b0; irq_pending = 1'b0;
    cyc(); chk("irq_entry_end", 64'(upc), 64'd65);
    cyc(); chk("irq_back_fetch", 64'(fetch_rd), 64'd1);

    // HALT with ime=0: wake on irq_pending without acknowledging
    disp_rom[8'h76] = 7'd70;
    w = payload(); w[END_BIT] = 1'b1; w[HALT_BIT] = 1'b1; ctrl_rom[70] = w;
    issue(8'h76);
    acks = 0; hcnt = 0;
    cyc(); chk("halt_word_upc", 64'(upc), 64'd70);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (halted && !ctrl_valid && !fetch_rd) hcnt++;
      if (irq_ack) acks++;
      if (i == 9) irq_pending = 1'b1;
    end
    cyc();
    if (irq_ack) acks++;
    chk("halt_cycles", 64'(hcnt), 64'd10);
    chk("halt_exit_fetch", 64'(fetch_rd), 64'd1);
    chk("halt_exit_halted", 64'(halted), 64'd0);
    chk("halt_no_ack", 64'(acks), 64'd0);
    irq_pending = 1'b0;

    // HALT bit and pending interrupt on the same END: HALT first, INT at the next END
    issue(8'h76);
    cyc(); irq_pending = 1'b1; ime = 1'b1;
    cyc(); chk("hw_halted", 64'(halted), 64'd1);
    chk("hw_no_ack", 64'(irq_ack), 64'd0);
    cyc(); chk("hw_exit_fetch", 64'(fetch_rd), 64'd1);
    mem_data = 8'h00; mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0;
    cyc(); chk("hw_nop_upc", 64'(upc), 64'd5);
    cyc(); chk("hw_int_ack", 64'(irq_ack), 64'd1);
    cyc(); chk("hw_int_upc", 64'(upc), 64'(INT_UPC));
    ime = 1'b0; irq_pending = 1'b0;
    cyc();
    cyc(); chk("hw_back_fetch", 64'(fetch_rd), 64'd1);

`ifdef GB_CB_PREFIX_EN
    // Prefixed opcode: two fetches, dispatch offset by CB_BASE
    disp_rom[8'h37] = 7'd9;
    w = payload(); w[END_BIT] = 1'b1; ctrl_rom[41] = w;
    issue(8'hCB);
    chk("cb_pc_inc1", 64'(pc_inc), 64'd1);
    cyc(); chk("cb_second_fetch", 64'(fetch_rd), 64'd1);
    mem_data = 8'h37; mem_ready = 1'b1;
    cyc(); mem_ready = 1'b0;
    chk("cb_pc_inc2", 64'(pc_inc), 64'd1);
    cyc(); chk("cb_upc", 64'(upc), 64'd41);
    chk("cb_valid", 64'(ctrl_valid), 64'd1);
    cyc(); chk("cb_back_fetch", 64'(fetch_rd), 64'd1);
`endif

    // Reset while stalled on a memory subop
    issue(8'h3E);
    mem_ready = 1'b1;
    cyc(); chk("rs_upc0", 64'(upc), 64'd10);
    cyc(); chk("rs_upc1", 64'(upc), 64'd11);
    mem_ready = 1'b0;
    cyc(); chk("rs_stall_hold", 64'(upc), 64'd11);
    rst = 1'b1;
    #1;
    chk("rs_fetch_rd",   64'(fetch_rd),   64'd0);
    chk("rs_ctrl_valid", 64'(ctrl_valid), 64'd0);
    chk("rs_ctrl_out",   64'(ctrl_out),   64'd0);
    chk("rs_upc",        64'(upc),        64'd0);
    chk("rs_flags",      64'({pc_inc, irq_ack, halted}), 64'd0);
    cyc();
    rst = 1'b0;
    cyc(); chk("rs_release_fetch", 64'(fetch_rd), 64'd1);
    chk("rs_release_valid", 64'(ctrl_valid), 64'd0);

    // Randomized program against the instruction-level model
    for (int i = 0; i < 256; i++) disp_rom[i] = 7'($urandom_range(0, 127));
    for (int i = 0; i < 128; i++) begin
      w = payload();
      w[END_BIT] = ($urandom_range(0, 2) == 0);
      w[MEM_BIT] = ($urandom_range(0, 2) == 0);
      ctrl_rom[i] = w;
    end
    ctrl_rom[127][END_BIT] = 1'b1;
    exp_q.delete();
    exp_pc = 0;
    for (int c = 0; c < 2500; c++) begin
      cyc();
      mem_ready = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if (b == 8'hCB) b = 8'h00;
      mem_data = b;
      chk("rnd_pc_inc", 64'(pc_inc), 64'(exp_pc));
      if (ctrl_valid) begin
        chk("rnd_ctrl_word", 64'(ctrl_out), 64'(ctrl_rom[upc]));
        if (!(ctrl_rom[upc][MEM_BIT] && !mem_ready)) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rnd_upc: got 0x%0h, expected no control word", upc);
          end else begin
            e = exp_q.pop_front();
            chk("rnd_upc", 64'(upc), 64'(e));
          end
        end
      end else begin
        chk("rnd_idle_zero", 64'(ctrl_out), 64'd0);
      end
      if (c % 50 == 0) chk("rnd_no_irq_halt", 64'({irq_ack, halted}), 64'd0);
      exp_pc = (fetch_rd && mem_ready) ? 1 : 0;
      if (exp_pc != 0) push_walk(disp_rom[mem_data]);
    end
    mem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
